// File: rtl/uint_to_float_pkg.sv
// rtl/uint_to_float_pkg.sv - shared widths, constants and float field layout for the uint32 to float32 converter
package uint_to_float_pkg;

  localparam int WORD_W   = 32;
  localparam int CLZ_W    = 6;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int FP_BIAS  = 127;
  localparam int EXP_BASE = FP_BIAS + WORD_W - 1;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } float_t;

endpackage

// File: rtl/count_leading_zeros.sv
// rtl/count_leading_zeros.sv - combinational leading-zero count of a 32-bit word, 32 for a zero word
module count_leading_zeros
  import uint_to_float_pkg::*;
(
  input  logic [WORD_W-1:0] i_WORD,
  output logic [CLZ_W-1:0]  o_COUNT
);

  // Ascending scan so the highest set bit is the last writer.
  always_comb begin
    o_COUNT = CLZ_W'(WORD_W);
    for (int i = 0; i < WORD_W; i++) begin
      if (i_WORD[i]) o_COUNT = CLZ_W'(WORD_W - 1 - i);
    end
  end

endmodule

// File: rtl/uint32_to_float32.sv
// rtl/uint32_to_float32.sv - two-stage uint32 to IEEE-754 single converter; UINT_TO_FLOAT_ROUND_EN selects round-to-nearest-even over truncation
module uint32_to_float32
  import uint_to_float_pkg::*;
(
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_VALID,
  output logic              o_READY,
  input  logic [WORD_W-1:0] i_WORD,
  output logic              o_VALID,
  input  logic              i_READY,
  output logic [WORD_W-1:0] o_FLOAT
);

  logic              s1_valid;
  logic [WORD_W-1:0] s1_word;
  logic [CLZ_W-1:0]  s1_clz;
  logic              s2_valid;
  float_t            s2_float;

  logic              s1_advance;
  logic              s2_advance;
  logic [CLZ_W-1:0]  clz;
  logic [EXP_W-1:0]  exp_raw;
  logic [MANT_W-1:0] mant;
  float_t            result;

  count_leading_zeros u_clz (
    .i_WORD  (i_WORD),
    .o_COUNT (clz)
  );

  assign s2_advance = !s2_valid || i_READY;
  assign s1_advance = !s1_valid || s2_advance;
  assign o_READY    = s1_advance && !i_RST;
  assign o_VALID    = s2_valid;
  assign o_FLOAT    = s2_float;

  assign exp_raw = EXP_W'(EXP_BASE) - EXP_W'(s1_clz);

`ifdef UINT_TO_FLOAT_ROUND_EN
  logic [WORD_W-2:0]       frac;
  logic                    round_up;
  logic [EXP_W+MANT_W-1:0] exp_mant;

  // Normalized word without its hidden leading one: mant, then guard, then sticky bits.
  assign frac     = (WORD_W-1)'(s1_word << s1_clz);
  assign mant     = frac[WORD_W-2 -: MANT_W];
  assign round_up = frac[WORD_W-2-MANT_W] && ((|frac[WORD_W-3-MANT_W:0]) || mant[0]);
  // A mantissa carry ripples straight into the exponent field.
  assign exp_mant = {exp_raw, mant} + {{(EXP_W+MANT_W-1){1'b0}}, round_up};
`else
  logic [EXP_W+MANT_W-1:0] exp_mant;

  assign mant     = MANT_W'((s1_word << s1_clz) >> (WORD_W - 1 - MANT_W));
  assign exp_mant = {exp_raw, mant};
`endif

  always_comb begin
    result = '0;
    if (s1_clz != CLZ_W'(WORD_W)) begin
      result = float_t'({1'b0, exp_mant});
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
      s1_clz   <= '0;
      s2_valid <= 1'b0;
      s2_float <= '0;
    end else begin
      if (s2_advance) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_float <= result;
      end
      if (s1_advance) begin
        s1_valid <= i_VALID;
        if (i_VALID) begin
          s1_word <= i_WORD;
          s1_clz  <= clz;
        end
      end
    end
  end

endmodule

// File: tb/tb_uint32_to_float32.sv
// tb/tb_uint32_to_float32.sv - scoreboard bench for uint32_to_float32 (honours UINT_TO_FLOAT_ROUND_EN)
module tb_uint32_to_float32;

  logic        i_CLK = 1'b0;
  logic        i_RST;
  logic        i_VALID;
  logic        o_READY;
  logic [31:0] i_WORD;
  logic        o_VALID;
  logic        i_READY;
  logic [31:0] o_FLOAT;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];

  uint32_to_float32 dut (
    .i_CLK   (i_CLK),
    .i_RST   (i_RST),
    .i_VALID (i_VALID),
    .o_READY (o_READY),
    .i_WORD  (i_WORD),
    .o_VALID (o_VALID),
    .i_READY (i_READY),
    .o_FLOAT (o_FLOAT)
  );

  always #5 i_CLK = ~i_CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, expv);
  endtask

  // Reference conversion goes through the exact double image of the integer.
  function automatic logic [31:0] ref_float(input logic [31:0] w);
    real         r;
    logic [63:0] d;
    logic [22:0] m;
    logic [28:0] rest;
    logic [30:0] em;
    if (w == 32'd0) return 32'd0;
    r    = real'(longint'({32'h0, w}));
    d    = $realtobits(r);
    m    = d[51:29];
    rest = d[28:0];
    em   = {8'(d[62:52] - 11'd896), m};
`ifdef UINT_TO_FLOAT_ROUND_EN
    if (rest[28] && ((|rest[27:0]) || m[0])) em = em + 31'd1;
`endif
    return {1'b0, em};
  endfunction

  task automatic tick(input logic v, input logic [31:0] w, input logic r, input logic [31:0] expv,
                      output logic acc, output logic ofire);
    @(negedge i_CLK);
    i_VALID = v;
    i_WORD  = w;
    i_READY = r;
    #1;
    acc   = v && o_READY;
    ofire = o_VALID && r;
    if (ofire) begin
      if (exp_q.size() == 0) check("unexpected_out", 32'(o_VALID), 32'd0);
      else check("result", o_FLOAT, exp_q.pop_front());
    end
    if (acc) exp_q.push_back(expv);
  endtask

  task automatic drain();
    logic a, o;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(1'b0, 32'd0, 1'b1, 32'd0, a, o);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        acc, of;
    logic [4:0]  ofs;
    logic [31:0] words[$];
    logic [31:0] held;
    logic        have_held;
    int          idx, nout;

    i_RST = 1'b1; i_VALID = 1'b0; i_WORD = '0; i_READY = 1'b0;
    repeat (2) @(negedge i_CLK);
    #1;
    check("rst_ready", 32'(o_READY), 32'd0);
    check("rst_valid", 32'(o_VALID), 32'd0);
    check("rst_float", o_FLOAT, 32'd0);
    @(negedge i_CLK);
    i_RST = 1'b0;
    #1;
    check("ready_after_rst", 32'(o_READY), 32'd1);

    // single word, two-cycle latency
    tick(1'b1, 32'h0000_8228, 1'b1, 32'h4702_2800, acc, of);
    check("t1_accept", 32'(acc), 32'd1);
    tick(1'b0, 32'd0, 1'b1, 32'd0, acc, of);
    check("t1_lat1", 32'(o_VALID), 32'd0);
    tick(1'b0, 32'd0, 1'b1, 32'd0, acc, of);
    check("t1_lat2", 32'(o_VALID), 32'd1);

    // back-to-back without bubbles
    words = '{32'd0, 32'd1, 32'h8000_0000};
    ofs = '0;
    tick(1'b1, words[0], 1'b1, 32'h0000_0000, acc, of); ofs[0] = of;
    tick(1'b1, words[1], 1'b1, 32'h3F80_0000, acc, of); ofs[1] = of;
    tick(1'b1, words[2], 1'b1, 32'h4F00_0000, acc, of); ofs[2] = of;
    tick(1'b0, 32'd0, 1'b1, 32'd0, acc, of); ofs[3] = of;
    tick(1'b0, 32'd0, 1'b1, 32'd0, acc, of); ofs[4] = of;
    check("b2b_pattern", 32'(ofs), 32'h1C);

    // rounding boundary words
`ifdef UINT_TO_FLOAT_ROUND_EN
    tick(1'b1, 32'hFFFF_FFFF, 1'b1, 32'h4F80_0000, acc, of);
    tick(1'b1, 32'h0100_0003, 1'b1, 32'h4B80_0002, acc, of);
`else
    tick(1'b1, 32'hFFFF_FFFF, 1'b1, 32'h4F7F_FFFF, acc, of);
    tick(1'b1, 32'h0100_0003, 1'b1, 32'h4B80_0001, acc, of);
`endif
    drain();

    // random words under random downstream stalls
    words.delete();
    for (int i = 0; i < 40; i++) words.push_back($urandom() >> $urandom_range(0, 31));
    words.push_back(32'h0100_0001);
    words.push_back(32'h00FF_FFFF);
    words.push_back(32'h0300_0080);
    idx = 0;
    for (int c = 0; c < 1000 && idx < words.size(); c++) begin
      tick(1'b1, words[idx], ($urandom_range(0, 3) != 0), ref_float(words[idx]), acc, of);
      if (acc) idx++;
    end
    check("rand_all_sent", 32'(idx), 32'(words.size()));
    drain();

    // backpressure: 4 words, downstream stalled 5 cycles
    words = '{32'h0000_0003, 32'h0000_0010, 32'h1234_5678, 32'hFFFF_0000};
    idx = 0; nout = 0; have_held = 1'b0; held = '0;
    for (int c = 0; c < 5; c++) begin
      tick(1'b1, words[idx], 1'b0, ref_float(words[idx]), acc, of);
      if (acc) idx++;
      if (o_VALID) begin
        if (!have_held) begin held = o_FLOAT; have_held = 1'b1; end
        else check("bp_stable", o_FLOAT, held);
      end
    end
    check("bp_accepts", 32'(idx), 32'd2);
    check("bp_ready_low", 32'(o_READY), 32'd0);
    for (int c = 0; c < 50 && (idx < 4 || exp_q.size() != 0); c++) begin
      if (idx < 4) tick(1'b1, words[idx], 1'b1, ref_float(words[idx]), acc, of);
      else tick(1'b0, 32'd0, 1'b1, 32'd0, acc, of);
      if (acc) idx++;
      if (of) nout++;
    end
    check("bp_outs", 32'(nout), 32'd4);
    drain();

    // reset with both stages full
    tick(1'b1, 32'h0000_0005, 1'b0, ref_float(32'h5), acc, of);
    tick(1'b1, 32'h0000_0007, 1'b0, ref_float(32'h7), acc, of);
    tick(1'b1, 32'h0000_0009, 1'b0, ref_float(32'h9), acc, of);
    check("full_ready_low", 32'(o_READY), 32'd0);
    @(negedge i_CLK);
    i_RST = 1'b1; i_VALID = 1'b1; i_WORD = 32'h0000_000B; i_READY = 1'b0;
    #1;
    check("rst_mid_ready", 32'(o_READY), 32'd0);
    @(negedge i_CLK);
    #1;
    check("rst_mid_valid", 32'(o_VALID), 32'd0);
    check("rst_mid_float", o_FLOAT, 32'd0);
    exp_q.delete();
    i_RST = 1'b0; i_VALID = 1'b0;
    #1;
    check("rst_mid_ready_after", 32'(o_READY), 32'd1);
    nout = 0;
    for (int c = 0; c < 6; c++) begin
      tick(1'b0, 32'd0, 1'b1, 32'd0, acc, of);
      if (of) nout++;
    end
    check("no_stale", 32'(nout), 32'd0);
    tick(1'b1, 32'h0000_8228, 1'b1, 32'h4702_2800, acc, of);
    check("post_rst_accept", 32'(acc), 32'd1);
    tick(1'b0, 32'd0, 1'b1, 32'd0, acc, of);
    check("post_rst_lat1", 32'(o_VALID), 32'd0);
    tick(1'b0, 32'd0, 1'b1, 32'd0, acc, of);
    check("post_rst_lat2", 32'(o_VALID), 32'd1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uint32_to_float32.md
# uint32_to_float32

Two-stage pipelined converter that turns a 32-bit unsigned integer word into an IEEE-754 single-precision value. It sits directly downstream of `count_leading_zeros`: it instantiates that block to find the normalization shift, then performs shift, exponent generation and optional rounding. A valid/ready handshake runs on both sides, so it drops into streaming arithmetic datapaths at full throughput.

## Interface
- Parameters: none. Widths are fixed by package constants.
- `i_CLK`  in  1  clock; all state updates on the rising edge.
- `i_RST`  in  1  synchronous, active-high reset.
- `i_VALID`  in  1  input word valid.
- `o_READY`  out  1  converter can accept a word this cycle.
- `i_WORD`  in  32  unsigned integer to convert.
- `o_VALID`  out  1  `o_FLOAT` holds a result.
- `i_READY`  in  1  downstream accepts the result.
- `o_FLOAT`  out  32  IEEE-754 single: sign, exp[7:0], mant[22:0].

## Operation
- **Stage 1 (S1)**
  - On an accept (`i_VALID && o_READY`), register `i_WORD` and `count_leading_zeros.o_COUNT[5:0]`.
  - `o_COUNT` is 0–31, or 32 for a zero word.
- **Stage 2 (S2)**
  - `shifted[31:0] = word << clz`.
  - `exp = 158 - clz`, i.e. BIAS 127 + 31 - clz, in 8 bits.
  - `mant = shifted[30:8]`.
  - Sign is always 0.
- **Zero word** (clz = 32): result is exactly `0x00000000`. No exponent arithmetic is applied.
- **Rounding** (`ROUND_EN` only): guard = `shifted[7]`, sticky = OR of `shifted[6:0]`.
  - Round up when guard && (sticky || mant[0]).
  - If `mant` is all ones, rounding up gives mant = 0 and exp + 1.
  - Maximum exponent after rounding is 159; overflow to infinity cannot occur.
- **Handshake**
  - S2 advances when `!s2_valid || i_READY`.
  - S1 advances when `!s1_valid || s2_advance`.
  - `o_READY = s1_advance && !i_RST`.
  - `o_VALID = s2_valid`.
  - `o_FLOAT` holds stable while `o_VALID && !i_READY`.
- **No state machine.** Control is the two valid bits only, with 4 combinations, all legal.
- **Simultaneous events**
  - Accept into S1, S1→S2 transfer, and S2 output in the same cycle are all legal and lose no data.
  - A full pipeline with `i_READY` low deasserts `o_READY` in the same cycle (combinational).

## Timing
- Latency: word accepted at edge N gives `o_VALID` high after edge N+1 (2 registers).
- Throughput: 1 word per cycle while `i_READY` stays high.
- Reset values: `o_VALID` = 0, `o_FLOAT` = `0x00000000`, internal valid bits = 0.
- `o_READY` = 0 while `i_RST` is high, and 1 in the first cycle after reset.
- Reset mid-operation: in-flight words in S1/S2 are discarded at the reset edge and nothing is emitted for them.
- Critical path: the S2 barrel shift plus the 24-bit round increment.
  - `count_leading_zeros` is combinational and is confined to S1's input side.

## Configuration
- `UINT_TO_FLOAT_ROUND_EN` **defined**: round-to-nearest-even on the 8 discarded bits, including the mantissa-carry exponent bump.
- **Not defined**: truncation (round toward zero). Guard, sticky and increment logic are absent.
  - Results differ from RNE only for inputs ≥ 2^24 with nonzero discarded bits.

## Structure
- **Shared package `uint_to_float_pkg`** holds:
  - `WORD_W` = 32, `CLZ_W` = 6, `EXP_W` = 8, `MANT_W` = 23.
  - `FP_BIAS` = 127, `EXP_BASE` = 158.
  - A packed struct typedef for the float fields {sign, exp, mant}.
- **One sub-module:** existing `count_leading_zeros` (ports `i_WORD` → `o_COUNT[5:0]`), instantiated once in S1.
- Shift/round logic stays inline in S2. No further sub-module is warranted.

## Test plan
- `0x00008228` with `i_READY` = 1 → `o_VALID` 2 cycles later with `o_FLOAT` = `0x47022800` (33320.0).
- Sequence 0, 1, `0x80000000` back-to-back → `0x00000000`, `0x3F800000`, `0x4F000000` on consecutive cycles with no bubbles.
- `0xFFFFFFFF` and `0x01000003`:
  - With `UINT_TO_FLOAT_ROUND_EN` → `0x4F800000` and `0x4B800002`.
  - Without it → `0x4F7FFFFF` and `0x4B800001`.
- Backpressure: stream 4 words while holding `i_READY` = 0 for 5 cycles.
  - `o_READY` drops after 2 accepts.
  - `o_FLOAT` stays stable.
  - All 4 results emerge in order once `i_READY` = 1.
- Reset mid-stream: assert `i_RST` for 1 cycle with both stages full.
  - `o_VALID` = 0 and `o_FLOAT` = 0 after the edge.
  - No stale results appear afterwards.
  - A new word converts normally with 2-cycle latency.
